// File: rtl/spi_matrix_pkg.sv
// Shared types and defaults for the matrix SPI receive path.
package spi_matrix_pkg;

  localparam int unsigned SPI_SIZE_DEF     = 24;
  localparam int unsigned WORDS_PER_MATRIX = 128;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_PARTIAL, ERR_OVERFLOW, ERR_TIMEOUT} rx_err_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input plus a rising-edge strobe on the synced value.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic I_rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!I_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_o = r_sync[SYNC_STAGES-1];
  assign rise_o = sync_o & ~r_prev;

endmodule

// File: rtl/spi_matrix_rx.sv
// Oversampling SPI word deserializer with per-frame word indexing and error reporting.
// Optional macro SPI_MATRIX_RX_EXTRA_BIT_EN: one extra trailing bit per word on extra_bit_o.
module spi_matrix_rx
  import spi_matrix_pkg::*;
#(
  parameter int unsigned SPI_SIZE        = SPI_SIZE_DEF,
  parameter int unsigned MSB_FIRST       = 1,
  parameter int unsigned WORDS_PER_FRAME = WORDS_PER_MATRIX,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                               clk,
  input  logic                               I_rst_n,
  input  logic                               spi_clk_i,
  input  logic                               spi_mosi_i,
  input  logic                               latch_i,
  output logic [SPI_SIZE-1:0]                word_o,
  output logic                               word_valid_o,
  output logic [$clog2(WORDS_PER_FRAME)-1:0] word_idx_o,
  output logic                               frame_done_o,
  output logic [$clog2(WORDS_PER_FRAME):0]   frame_words_o,
  output logic                               err_o,
`ifdef SPI_MATRIX_RX_EXTRA_BIT_EN
  output logic                               extra_bit_o,
`endif
  output logic [1:0]                         err_code_o
);

`ifdef SPI_MATRIX_RX_EXTRA_BIT_EN
  localparam int unsigned BITS = SPI_SIZE + 1;
`else
  localparam int unsigned BITS = SPI_SIZE;
`endif
  localparam int unsigned CNT_W  = $clog2(BITS + 1);
  localparam int unsigned IDX_W  = $clog2(WORDS_PER_FRAME);
  localparam int unsigned WCNT_W = IDX_W + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS - 1);
  localparam logic [WCNT_W-1:0] WPF_C    = WCNT_W'(WORDS_PER_FRAME);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic w_clk_rise, w_mosi_sync, w_latch_rise;
  logic w_unused_clk_sync, w_unused_mosi_rise, w_unused_latch_sync;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk    (clk),
    .I_rst_n(I_rst_n),
    .async_i(spi_clk_i),
    .sync_o (w_unused_clk_sync),
    .rise_o (w_clk_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .I_rst_n(I_rst_n),
    .async_i(spi_mosi_i),
    .sync_o (w_mosi_sync),
    .rise_o (w_unused_mosi_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk    (clk),
    .I_rst_n(I_rst_n),
    .async_i(latch_i),
    .sync_o (w_unused_latch_sync),
    .rise_o (w_latch_rise)
  );

  logic r_mosi_d, r_rise, r_bit, r_latch;

  rx_state_t           r_state, w_state_nxt;
  logic [BITS-1:0]     r_shift, w_shift_nxt, w_shift_in;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [TO_W-1:0]     r_idle_cnt, w_idle_cnt_nxt;
  logic [WCNT_W-1:0]   r_word_cnt, w_word_cnt_nxt;

  logic [SPI_SIZE-1:0] r_word, w_word_nxt, w_word_data;
  logic                r_word_valid, w_word_valid_nxt;
  logic [IDX_W-1:0]    r_word_idx, w_word_idx_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic [WCNT_W-1:0]   r_frame_words, w_frame_words_nxt;
  logic                r_err, w_err_nxt;
  rx_err_t             r_err_code, w_err_code_nxt;
  logic                w_complete;

  // The mosi delay lines its sample up with the registered clock edge strobe.
  always_ff @(posedge clk) begin
    if (!I_rst_n) begin
      r_mosi_d <= 1'b0;
      r_rise   <= 1'b0;
      r_bit    <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_mosi_d <= w_mosi_sync;
      r_rise   <= w_clk_rise;
      r_bit    <= r_mosi_d;
      r_latch  <= w_latch_rise;
    end
  end

  always_comb begin
    if (MSB_FIRST != 0) w_shift_in = {r_shift[BITS-2:0], r_bit};
    else                w_shift_in = {r_bit, r_shift[BITS-1:1]};
  end

`ifdef SPI_MATRIX_RX_EXTRA_BIT_EN
  logic r_extra, w_extra_data;

  // The trailing wire bit is the extra bit regardless of data bit order.
  assign w_word_data  = (MSB_FIRST != 0) ? w_shift_in[BITS-1:1] : w_shift_in[SPI_SIZE-1:0];
  assign w_extra_data = (MSB_FIRST != 0) ? w_shift_in[0] : w_shift_in[BITS-1];

  always_ff @(posedge clk) begin
    if (!I_rst_n)              r_extra <= 1'b0;
    else if (w_word_valid_nxt) r_extra <= w_extra_data;
  end

  assign extra_bit_o = r_extra;
`else
  assign w_word_data = w_shift_in;
`endif

  assign w_complete = r_rise && (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_idle_cnt_nxt    = r_idle_cnt;
    w_word_cnt_nxt    = r_word_cnt;
    w_word_nxt        = r_word;
    w_word_valid_nxt  = 1'b0;
    w_word_idx_nxt    = r_word_idx;
    w_frame_done_nxt  = 1'b0;
    w_frame_words_nxt = '0;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = ERR_NONE;

    unique case (r_state)
      IDLE: begin
        if (r_rise) begin
          w_shift_nxt    = w_shift_in;
          w_bit_cnt_nxt  = CNT_W'(1);
          w_idle_cnt_nxt = '0;
          w_state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (r_rise) begin
          w_shift_nxt    = w_shift_in;
          w_idle_cnt_nxt = '0;
          if (w_complete) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            if (r_word_cnt < WPF_C) begin
              w_word_nxt       = w_word_data;
              w_word_valid_nxt = 1'b1;
              w_word_idx_nxt   = r_word_cnt[IDX_W-1:0];
              w_word_cnt_nxt   = r_word_cnt + WCNT_W'(1);
            end else begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_OVERFLOW;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end else if (r_idle_cnt == TO_LAST) begin
          w_state_nxt    = IDLE;
          w_bit_cnt_nxt  = '0;
          w_idle_cnt_nxt = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A word finishing on the latch cycle is counted before the frame closes.
    if (r_latch) begin
      w_frame_done_nxt  = 1'b1;
      w_frame_words_nxt = w_word_cnt_nxt;
      w_word_cnt_nxt    = '0;
      if ((r_state == SHIFT) && (r_bit_cnt != '0) && !w_complete) begin
        w_state_nxt    = IDLE;
        w_bit_cnt_nxt  = '0;
        w_idle_cnt_nxt = '0;
        w_err_nxt      = 1'b1;
        w_err_code_nxt = ERR_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!I_rst_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_word_cnt    <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_word_idx    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_words <= '0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_word        <= w_word_nxt;
      r_word_valid  <= w_word_valid_nxt;
      r_word_idx    <= w_word_idx_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_frame_words <= w_frame_words_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
    end
  end

  assign word_o        = r_word;
  assign word_valid_o  = r_word_valid;
  assign word_idx_o    = r_word_idx;
  assign frame_done_o  = r_frame_done;
  assign frame_words_o = r_frame_words;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;

endmodule
